cu_edge_data_read_command_generator: RTL and testbench
======================================================

# cu_edge_data_read_command_generator

Upstream feeder of the PageRank CSR PULL vertex cache reuse stage. Converts a stream of edge jobs (destination vertex IDs) into vertex-data read commands aligned to 128-byte cachelines. Optionally coalesces back-to-back edges hitting the same cacheline into one command. Throttles against read-buffer back-pressure and an outstanding-read credit limit.

## Interface
- NUM_VERTEX_CU, NUM_VERTEX_CU_GLOBAL: CU count, used for cu_id tagging
- FIFO_DEPTH, 16: edge-job input FIFO entries (power of 2)
- MAX_OUTSTANDING, 32: maximum issued-but-unanswered read commands
- DATA_SIZE_BYTES, 8: bytes per vertex datum
- clock  in  1  clock
- rstn_in  in  1  asynchronous, active-low reset
- enabled_in  in  1  block enable
- wed_request_in  in  WEDInterface  supplies the vertex-data base address (array_receive)
- edge_job_in  in  EdgeInterface  valid plus 32-bit dest vertex ID
- edge_job_request_out  out  1  pull request to the edge-job producer
- read_buffer_status  in  BufferStatus  downstream command buffer; alfull stalls issue
- read_response_in  in  ResponseBufferLine  valid returns one credit
- read_command_out  out  CommandBufferLine  registered read command (cacheline address, size 128, cu_id, cmd_type READ)
- edges_processed_out  out  32  edges consumed since reset
- commands_issued_out  out  32  commands issued since reset

## Operation
- Input stage registers all inputs once (valid and payload separately).
- FSM states:
  - RESET_ST: after reset, go to WAIT_WED.
  - WAIT_WED: capture the base address on wed_request_in.valid, then go to ACTIVE.
  - ACTIVE: issue commands.
  - STALL: entered when alfull is set or outstanding == MAX_OUTSTANDING; return to ACTIVE when both clear.
  - enabled_in low freezes the FSM and forces edge_job_request_out to 0. FIFO contents are held.
- Address: base + dest_id*DATA_SIZE_BYTES, computed in 64-bit arithmetic, low 7 bits cleared. Wrap beyond 2^64 is not checked.
- edge_job_request_out = enabled && state ∈ {ACTIVE, STALL} && fifo_count < FIFO_DEPTH-2. The 2-entry margin covers producer latency.
- Valid edge_job_in writes to the FIFO.
- In ACTIVE, pop one entry per cycle and increment edges_processed_out.
  - Emit a command unless it is coalesced.
  - On each emit, increment commands_issued_out and outstanding.
- Credits: response-only cycle → outstanding-1. Issue-only → +1. Both → unchanged. outstanding never underflows: a response at 0 is ignored.
- FIFO full with valid input: entry dropped and sticky overflow flag set (debug only). This cannot occur with a compliant producer.
- Reset mid-operation: FIFO, counters, credits and the last-line register are all cleared. In-flight responses after reset are ignored until the next WED.

## Timing
- Reset value of every output: all 0, including read_command_out.valid and payload.
- Latency: edge_job_in accepted at cycle N → FIFO write N+1 → pop/address N+2 → read_command_out.valid at N+3, if no stall.
- Throughput: 1 command per cycle sustained.
- Stall detection uses the latched alfull, so at most one command is issued after alfull rises.
- read_command_out.valid is a single-cycle pulse per command. There is no ready handshake; alfull is the only back-pressure.

## Configuration
- CU_EDGE_CMD_COALESCE_EN:
  - Defined: a pop whose cacheline equals the last issued cacheline (tracked by a valid bit plus a 57-bit tag) produces no command. It still counts in edges_processed_out.
  - The last-line valid bit clears on reset, on a new WED, and when the FIFO runs empty for one cycle.
  - Undefined: every popped edge issues a command, and the comparator logic is absent.

## Structure
- Shared CU_PKG holds:
  - the state enum cu_edge_cmd_state (RESET_ST, WAIT_WED, ACTIVE, STALL)
  - CACHELINE_ADDR_BITS = 7
  - MAX_OUTSTANDING_DEFAULT
- One sub-module, fifo_edge_job: synchronous FIFO with count, full and empty outputs, parameterised on depth and payload type.

## Test plan
- Base 0x1000; dest IDs 0,1,2 → one command at address 0x1000 with coalescing on, three commands at 0x1000 with it off; edges_processed_out = 3.
- dest 15 then 16 → addresses 0x1000 and 0x1080 (16*8 = 128 boundary crosses a cacheline).
- Issue 32 commands with no responses → block enters STALL and the 33rd edge is held. One response → exactly one more command next cycle.
- Response and issue in the same cycle at outstanding = 10 → outstanding stays 10.
- alfull raised mid-stream → at most 1 further command; deassert → issue resumes within 2 cycles.
- Assert rstn_in low mid-burst → all outputs 0 next edge; after a new WED, the first command reflects the new base only.

Source files
------------

// File: rtl/cu_pkg.sv
// cu_pkg: shared compute-unit types and constants for the edge-data read command path.
package cu_pkg;
  typedef enum logic [1:0] {RESET_ST, WAIT_WED, ACTIVE, STALL} cu_edge_cmd_state;
  localparam int CACHELINE_ADDR_BITS = 7;
  localparam int CACHELINE_BYTES = 1 << CACHELINE_ADDR_BITS;
  localparam int MAX_OUTSTANDING_DEFAULT = 32;
  localparam logic [1:0] CMD_READ = 2'd1;
  function automatic logic [63:0] cacheline_align(input logic [63:0] addr);
    return {addr[63:CACHELINE_ADDR_BITS], {CACHELINE_ADDR_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/fifo_edge_job.sv
// fifo_edge_job: synchronous FIFO with occupancy count; writes while full are dropped.
module fifo_edge_job #(
  parameter int DEPTH = 16,
  parameter type T = logic [31:0],
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          rstn_in,
  input  logic          wr_i,
  input  T              wr_data_i,
  input  logic          rd_i,
  output T              rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  T mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic wr_en, rd_en;
  assign full_o = count_q == FULL_COUNT;
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign wr_en = wr_i && !full_o;
  assign rd_en = rd_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  always_ff @(posedge clock or negedge rstn_in)
    if (!rstn_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(wr_en);
      rd_ptr_q <= rd_ptr_q + AW'(rd_en);
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  always_ff @(posedge clock)
    if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
endmodule

// File: rtl/cu_edge_data_read_command_generator.sv
// cu_edge_data_read_command_generator: edge jobs -> cacheline-aligned vertex-data read commands, throttled
// by buffer alfull and read credits. Define CU_EDGE_CMD_COALESCE_EN to merge back-to-back same-line edges.
module cu_edge_data_read_command_generator
  import cu_pkg::*;
#(
  parameter int NUM_VERTEX_CU = 1,
  parameter int NUM_VERTEX_CU_GLOBAL = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
  parameter int DATA_SIZE_BYTES = 8,
  localparam int CU_ID_W = $clog2(NUM_VERTEX_CU_GLOBAL) + 1
) (
  input  logic               clock,
  input  logic               rstn_in,
  input  logic               enabled_in,
  input  logic               wed_valid_in,
  input  logic [63:0]        wed_array_receive_in,
  input  logic               edge_job_valid_in,
  input  logic [31:0]        edge_job_dest_in,
  output logic               edge_job_request_out,
  input  logic               read_buffer_alfull_in,
  input  logic               read_response_valid_in,
  output logic               read_command_valid_out,
  output logic [63:0]        read_command_address_out,
  output logic [7:0]         read_command_size_out,
  output logic [CU_ID_W-1:0] read_command_cu_id_out,
  output logic [1:0]         read_command_cmd_type_out,
  output logic [31:0]        edges_processed_out,
  output logic [31:0]        commands_issued_out,
  output logic               fifo_overflow_out
);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
  localparam logic [FCW-1:0] REQ_LIMIT = FCW'(FIFO_DEPTH - 2);
  logic enabled_q, wed_valid_q, edge_valid_q, alfull_q, resp_q;
  logic [63:0] wed_addr_q, base_q, line_addr;
  logic [31:0] edge_dest_q, head_dest, edges_q, cmds_q;
  cu_edge_cmd_state state_q;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic cmd_valid_q, overflow_q;
  logic [63:0] cmd_addr_q;
  logic [7:0] cmd_size_q;
  logic [CU_ID_W-1:0] cu_id_q;
  logic [1:0] cmd_type_q;
  logic [FCW-1:0] fifo_count;
  logic fifo_full, fifo_empty, run, stall, pop, hit, issue, resp_ok;
  always_ff @(posedge clock or negedge rstn_in)
    if (!rstn_in) begin
      enabled_q <= 1'b0;
      wed_valid_q <= 1'b0;
      wed_addr_q <= '0;
      edge_valid_q <= 1'b0;
      edge_dest_q <= '0;
      alfull_q <= 1'b0;
      resp_q <= 1'b0;
    end else begin
      enabled_q <= enabled_in;
      wed_valid_q <= wed_valid_in;
      wed_addr_q <= wed_array_receive_in;
      edge_valid_q <= edge_job_valid_in;
      edge_dest_q <= edge_job_dest_in;
      alfull_q <= read_buffer_alfull_in;
      resp_q <= read_response_valid_in;
    end
  fifo_edge_job #(.DEPTH(FIFO_DEPTH), .T(logic [31:0])) u_fifo (
    .clock(clock), .rstn_in(rstn_in),
    .wr_i(edge_valid_q), .wr_data_i(edge_dest_q),
    .rd_i(pop), .rd_data_o(head_dest),
    .count_o(fifo_count), .full_o(fifo_full), .empty_o(fifo_empty)
  );
  // STALL is left in the same cycle its causes clear, so the pop path looks at the causes directly
  assign run = state_q == ACTIVE || state_q == STALL;
  assign stall = alfull_q || outstanding_q == OUT_MAX;
  assign pop = enabled_q && run && !stall && !fifo_empty;
  assign issue = pop && !hit;
  assign resp_ok = resp_q && run && outstanding_q != '0;
  assign outstanding_d = outstanding_q + OW'(issue) - OW'(resp_ok);
  assign line_addr = cacheline_align(base_q + 64'(head_dest) * 64'(DATA_SIZE_BYTES));
  assign edge_job_request_out = enabled_q && run && fifo_count < REQ_LIMIT;
`ifdef CU_EDGE_CMD_COALESCE_EN
  logic last_vld_q;
  logic [63-CACHELINE_ADDR_BITS:0] last_tag_q;
  assign hit = last_vld_q && last_tag_q == line_addr[63:CACHELINE_ADDR_BITS];
  always_ff @(posedge clock or negedge rstn_in)
    if (!rstn_in) begin
      last_vld_q <= 1'b0;
      last_tag_q <= '0;
    end else if (wed_valid_q || fifo_empty) begin
      last_vld_q <= 1'b0;
    end else if (issue) begin
      last_vld_q <= 1'b1;
      last_tag_q <= line_addr[63:CACHELINE_ADDR_BITS];
    end
`else
  assign hit = 1'b0;
`endif
  always_ff @(posedge clock or negedge rstn_in)
    if (!rstn_in) begin
      state_q <= RESET_ST;
      base_q <= '0;
    end else if (enabled_q) begin
      case (state_q)
        RESET_ST: state_q <= WAIT_WED;
        WAIT_WED: if (wed_valid_q) begin
          base_q <= wed_addr_q;
          state_q <= ACTIVE;
        end
        ACTIVE: if (stall) state_q <= STALL;
        default: if (!stall) state_q <= ACTIVE;
      endcase
    end
  always_ff @(posedge clock or negedge rstn_in)
    if (!rstn_in) begin
      cmd_valid_q <= 1'b0;
      cmd_addr_q <= '0;
      cmd_size_q <= '0;
      cu_id_q <= '0;
      cmd_type_q <= '0;
      edges_q <= '0;
      cmds_q <= '0;
      outstanding_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      cmd_valid_q <= issue;
      if (issue) begin
        cmd_addr_q <= line_addr;
        cmd_size_q <= 8'(CACHELINE_BYTES);
        cu_id_q <= CU_ID_W'(NUM_VERTEX_CU);
        cmd_type_q <= CMD_READ;
      end
      edges_q <= edges_q + 32'(pop);
      cmds_q <= cmds_q + 32'(issue);
      outstanding_q <= outstanding_d;
      overflow_q <= overflow_q | (edge_valid_q & fifo_full);
    end
  assign read_command_valid_out = cmd_valid_q;
  assign read_command_address_out = cmd_addr_q;
  assign read_command_size_out = cmd_size_q;
  assign read_command_cu_id_out = cu_id_q;
  assign read_command_cmd_type_out = cmd_type_q;
  assign edges_processed_out = edges_q;
  assign commands_issued_out = cmds_q;
  assign fifo_overflow_out = overflow_q;
endmodule

// File: tb/tb_cu_edge_data_read_command_generator.sv
// tb_cu_edge_data_read_command_generator: directed checks of addressing, coalescing, credits, alfull and reset.
module tb_cu_edge_data_read_command_generator;
`ifdef CU_EDGE_CMD_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif
  logic clock = 1'b0;
  logic rstn_in = 1'b0;
  logic enabled_in = 1'b1;
  logic wed_valid_in = 1'b0;
  logic [63:0] wed_array_receive_in = '0;
  logic edge_job_valid_in = 1'b0;
  logic [31:0] edge_job_dest_in = '0;
  logic read_buffer_alfull_in = 1'b0;
  logic read_response_valid_in = 1'b0;
  logic edge_job_request_out, read_command_valid_out, fifo_overflow_out;
  logic [63:0] read_command_address_out;
  logic [7:0] read_command_size_out;
  logic [2:0] read_command_cu_id_out;
  logic [1:0] read_command_cmd_type_out;
  logic [31:0] edges_processed_out, commands_issued_out;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] addr_q [$];
  int stamp_q [$];

  cu_edge_data_read_command_generator #(.NUM_VERTEX_CU(2), .NUM_VERTEX_CU_GLOBAL(4)) dut (
    .clock(clock), .rstn_in(rstn_in), .enabled_in(enabled_in),
    .wed_valid_in(wed_valid_in), .wed_array_receive_in(wed_array_receive_in),
    .edge_job_valid_in(edge_job_valid_in), .edge_job_dest_in(edge_job_dest_in),
    .edge_job_request_out(edge_job_request_out),
    .read_buffer_alfull_in(read_buffer_alfull_in), .read_response_valid_in(read_response_valid_in),
    .read_command_valid_out(read_command_valid_out), .read_command_address_out(read_command_address_out),
    .read_command_size_out(read_command_size_out), .read_command_cu_id_out(read_command_cu_id_out),
    .read_command_cmd_type_out(read_command_cmd_type_out),
    .edges_processed_out(edges_processed_out), .commands_issued_out(commands_issued_out),
    .fifo_overflow_out(fifo_overflow_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock)
    if (read_command_valid_out) begin
      addr_q.push_back(read_command_address_out);
      stamp_q.push_back(cyc);
    end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  function automatic logic [63:0] addr_at(input int i);
    return (i < addr_q.size()) ? addr_q[i] : 64'hdead_dead;
  endfunction

  function automatic int stamp_at(input int i);
    return (i < stamp_q.size()) ? stamp_q[i] : -1000;
  endfunction

  task automatic clear_log();
    addr_q.delete();
    stamp_q.delete();
  endtask

  task automatic send_wed(input logic [63:0] b);
    wed_valid_in = 1'b1;
    wed_array_receive_in = b;
    tick(1);
    wed_valid_in = 1'b0;
    tick(3);
  endtask

  task automatic send_stream(input int first, input int step, input int n);
    for (int i = 0; i < n; i++) begin
      edge_job_valid_in = 1'b1;
      edge_job_dest_in = 32'(first + i * step);
      tick(1);
    end
    edge_job_valid_in = 1'b0;
  endtask

  task automatic restart(input logic [63:0] b);
    rstn_in = 1'b0;
    edge_job_valid_in = 1'b0;
    read_response_valid_in = 1'b0;
    read_buffer_alfull_in = 1'b0;
    tick(2);
    rstn_in = 1'b1;
    tick(3);
    send_wed(b);
    clear_log();
  endtask

  initial begin
    int c, t_al, d, after, first;
    tick(2);
    check("rst_valid", 64'(read_command_valid_out), 0);
    check("rst_addr", read_command_address_out, 0);
    check("rst_size", 64'(read_command_size_out), 0);
    check("rst_cu_id", 64'(read_command_cu_id_out), 0);
    check("rst_cmd_type", 64'(read_command_cmd_type_out), 0);
    check("rst_edges", 64'(edges_processed_out), 0);
    check("rst_cmds", 64'(commands_issued_out), 0);
    check("rst_request", 64'(edge_job_request_out), 0);
    rstn_in = 1'b1;
    tick(3);
    check("request_before_wed", 64'(edge_job_request_out), 0);
    send_wed(64'h1000);
    check("request_active", 64'(edge_job_request_out), 1);

    // dest 0,1,2 share the 0x1000 line
    clear_log();
    c = cyc;
    send_stream(0, 1, 3);
    tick(6);
    check("same_line_count", 64'(addr_q.size()), COAL ? 1 : 3);
    check("same_line_addr0", addr_at(0), 64'h1000);
    check("same_line_addr_last", addr_at(addr_q.size() - 1), 64'h1000);
    check("latency", 64'(stamp_at(0) - c), 3);
    check("same_line_edges", 64'(edges_processed_out), 3);
    check("same_line_cmds", 64'(commands_issued_out), COAL ? 1 : 3);

    // dest 15 -> 0x1078 (line 0x1000), dest 16 -> 0x1080
    clear_log();
    send_stream(15, 1, 2);
    tick(6);
    check("boundary_count", 64'(addr_q.size()), 2);
    check("boundary_addr0", addr_at(0), 64'h1000);
    check("boundary_addr1", addr_at(1), 64'h1080);
    check("cmd_size", 64'(read_command_size_out), 128);
    check("cmd_type", 64'(read_command_cmd_type_out), 1);
    check("cmd_cu_id", 64'(read_command_cu_id_out), 2);

    enabled_in = 1'b0;
    tick(2);
    check("request_disabled", 64'(edge_job_request_out), 0);
    enabled_in = 1'b1;
    tick(2);

    // reset in the middle of a burst
    clear_log();
    for (int i = 0; i < 4; i++) begin
      edge_job_valid_in = 1'b1;
      edge_job_dest_in = 32'(i * 16);
      tick(1);
    end
    rstn_in = 1'b0;
    edge_job_valid_in = 1'b0;
    tick(1);
    check("midrst_valid", 64'(read_command_valid_out), 0);
    check("midrst_addr", read_command_address_out, 0);
    check("midrst_edges", 64'(edges_processed_out), 0);
    check("midrst_cmds", 64'(commands_issued_out), 0);
    check("midrst_request", 64'(edge_job_request_out), 0);
    rstn_in = 1'b1;
    tick(3);
    send_wed(64'h20000);
    clear_log();
    send_stream(3, 1, 1);
    tick(6);
    check("newbase_count", 64'(addr_q.size()), 1);
    check("newbase_addr", addr_at(0), 64'h20000);
    check("newbase_edges", 64'(edges_processed_out), 1);

    // credit limit: 33 distinct lines, no responses
    restart(64'h1000);
    send_stream(0, 16, 33);
    tick(20);
    check("credit_cmd_count", 64'(addr_q.size()), 32);
    check("credit_edges_held", 64'(edges_processed_out), 32);
    check("credit_cmds", 64'(commands_issued_out), 32);
    c = cyc;
    read_response_valid_in = 1'b1;
    tick(1);
    read_response_valid_in = 1'b0;
    tick(8);
    check("credit_one_more", 64'(addr_q.size()), 33);
    check("credit_resume_delay", 64'(stamp_at(32) - c), 3);
    check("credit_33rd_addr", addr_at(32), 64'h1000 + 32 * 128);
    check("credit_edges_after", 64'(edges_processed_out), 33);

    // response and issue in the same cycle with 10 outstanding
    restart(64'h1000);
    send_stream(0, 16, 10);
    tick(6);
    check("same_cycle_pre", 64'(addr_q.size()), 10);
    edge_job_valid_in = 1'b1;
    edge_job_dest_in = 32'd160;
    tick(1);
    edge_job_valid_in = 1'b0;
    read_response_valid_in = 1'b1;
    tick(1);
    read_response_valid_in = 1'b0;
    tick(5);
    send_stream(176, 16, 30);
    tick(30);
    check("same_cycle_total", 64'(addr_q.size()), 33);
    check("same_cycle_cmds", 64'(commands_issued_out), 33);

    // alfull raised mid-stream, then released
    restart(64'h1000);
    t_al = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        read_buffer_alfull_in = 1'b1;
        t_al = cyc;
      end
      edge_job_valid_in = 1'b1;
      edge_job_dest_in = 32'(i * 16);
      tick(1);
    end
    edge_job_valid_in = 1'b0;
    tick(8);
    after = 0;
    foreach (stamp_q[i]) if (stamp_q[i] > t_al) after++;
    check("alfull_extra_cmds", 64'(after), 1);
    check("alfull_held_count", 64'(addr_q.size()), 4);
    d = cyc;
    read_buffer_alfull_in = 1'b0;
    tick(16);
    first = -1000;
    foreach (stamp_q[i]) if (first < 0 && stamp_q[i] > d) first = stamp_q[i];
    check("alfull_resume_delay", 64'(first - d), 2);
    check("alfull_total", 64'(addr_q.size()), 16);
    check("overflow_clear", 64'(fifo_overflow_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
